demod_byte_packer: RTL and testbench

Sits directly downstream of the final FIR stage of the FM demodulator chain. It buffers 16-bit signed demodulated samples in a small FIFO and serialises each sample into two bytes for the UART transmitter, using a valid/ready byte handshake. It absorbs bursty sample output against the slower UART drain rate and flags lost samples.

---
 rtl/demod_byte_packer.sv | 136 +++++++++++++
 tb/tb_demod_byte_packer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demod_byte_packer.sv
// Sample FIFO plus byte serialiser: buffers 16-bit demodulated samples and
// hands them to the UART transmitter as two bytes over a valid/ready handshake.
module demod_byte_packer #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       valid_i,
    output logic [7:0]                 byte_o,
    output logic                       byte_valid_o,
    input  logic                       byte_ready_i,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             overflow_reg;
    state_t           state_reg;
    logic [WIDTH-1:0] hold_reg;
    logic [7:0]       byte_reg;
    logic             byte_valid_reg;

    logic             full;
    logic             not_empty;
    logic             pop;
    logic             push;
    logic [WIDTH-1:0] rd_word;

    assign full      = (level_reg == LW'(DEPTH));
    assign not_empty = (level_reg != '0);
    // The FSM pops when idle, or on the final byte's handshake for back-to-back output.
    assign pop       = not_empty &&
                       ((state_reg == IDLE) || ((state_reg == BYTE1) && byte_ready_i));
    assign push      = valid_i && (!full || pop);
    assign rd_word   = mem[rd_ptr_reg];

    function automatic logic [7:0] first_byte(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1 -: 8] : w[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[7:0] : w[WIDTH-1 -: 8];
    endfunction

    // Storage carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
            if (valid_i && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            byte_reg       <= 8'h00;
            byte_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        hold_reg       <= rd_word;
                        byte_reg       <= first_byte(rd_word);
                        byte_valid_reg <= 1'b1;
                        state_reg      <= BYTE0;
                    end
                end
                BYTE0: begin
                    if (byte_ready_i) begin
                        byte_reg  <= second_byte(hold_reg);
                        state_reg <= BYTE1;
                    end
                end
                BYTE1: begin
                    if (byte_ready_i) begin
                        if (pop) begin
                            hold_reg  <= rd_word;
                            byte_reg  <= first_byte(rd_word);
                            state_reg <= BYTE0;
                        end else begin
                            byte_valid_reg <= 1'b0;
                            state_reg      <= IDLE;
                        end
                    end
                end
                default: begin
                    byte_valid_reg <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    assign byte_o       = byte_reg;
    assign byte_valid_o = byte_valid_reg;
    assign overflow_o   = overflow_reg;
    assign level_o      = level_reg;
    assign empty_o      = (level_reg == '0) && (state_reg == IDLE);

endmodule

// File: tb/tb_demod_byte_packer.sv
// Scoreboard bench: a queue-level model predicts accepted samples and byte
// order for an MSB-first and an LSB-first instance driven in parallel.
module tb_demod_byte_packer;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   data_i = '0;
    logic          valid_i = 1'b0;
    logic          byte_ready_i = 1'b0;

    logic [7:0]    byte_m, byte_l;
    logic          bv_m, bv_l, ovf_m, ovf_l, emp_m, emp_l;
    logic [LW-1:0] lvl_m, lvl_l;

    always #5 clk = ~clk;

    demod_byte_packer #(.WIDTH(16), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .byte_o(byte_m), .byte_valid_o(bv_m), .byte_ready_i(byte_ready_i),
        .overflow_o(ovf_m), .level_o(lvl_m), .empty_o(emp_m));

    demod_byte_packer #(.WIDTH(16), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .byte_o(byte_l), .byte_valid_o(bv_l), .byte_ready_i(byte_ready_i),
        .overflow_o(ovf_l), .level_o(lvl_l), .empty_o(emp_l));

    // Reference model: sample queue, bytes still owed for the sample in flight.
    logic [15:0] mq[$];
    int          pend = 0;
    bit          movf = 1'b0;
    logic [7:0]  exp_m[$];
    logic [7:0]  exp_l[$];
    bit          m_hs, m_pop;
    int          m_size;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_m.delete();
            exp_l.delete();
            pend = 0;
            movf = 1'b0;
        end else begin
            m_size = mq.size();
            m_hs   = (pend > 0) && byte_ready_i;
            m_pop  = (m_size > 0) && ((pend == 0) || (pend == 1 && m_hs));
            if (m_hs) pend = pend - 1;
            if (m_pop) begin
                void'(mq.pop_front());
                pend = 2;
            end
            if (valid_i) begin
                if (m_size < DEPTH || m_pop) begin
                    mq.push_back(data_i);
                    exp_m.push_back(data_i[15:8]);
                    exp_m.push_back(data_i[7:0]);
                    exp_l.push_back(data_i[7:0]);
                    exp_l.push_back(data_i[15:8]);
                end else begin
                    movf = 1'b1;
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;
    bit end_req = 1'b0;
    bit end_done = 1'b0;
    bit drain_timeout = 1'b0;
    logic [7:0] want;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_valid", int'(bv_m), 0);
                chk("rst_level", int'(lvl_m), 0);
                chk("rst_ovf", int'(ovf_m), 0);
                chk("rst_empty", int'(emp_m), 1);
                chk("rst_byte", int'(byte_m), 0);
            end else begin
                chk("valid", int'(bv_m), int'(pend > 0));
                chk("valid_lsb", int'(bv_l), int'(pend > 0));
                chk("level", int'(lvl_m), mq.size());
                chk("overflow", int'(ovf_m), int'(movf));
                chk("empty", int'(emp_m), int'(mq.size() == 0 && pend == 0));
                if (bv_m) begin
                    if (exp_m.size() == 0) begin
                        chk("extra_byte_msb", 1, 0);
                    end else begin
                        want = exp_m[0];
                        chk("byte_msb", int'(byte_m), int'(want));
                        if (byte_ready_i) begin
                            $display("byte msb=%02h ready=1 level=%0d", byte_m, lvl_m);
                            void'(exp_m.pop_front());
                        end
                    end
                end
                if (bv_l) begin
                    if (exp_l.size() == 0) begin
                        chk("extra_byte_lsb", 1, 0);
                    end else begin
                        want = exp_l[0];
                        chk("byte_lsb", int'(byte_l), int'(want));
                        if (byte_ready_i) void'(exp_l.pop_front());
                    end
                end
            end
            if (end_req && !end_done) begin
                chk("drain_timeout", int'(drain_timeout), 0);
                chk("leftover_msb", exp_m.size(), 0);
                chk("leftover_lsb", exp_l.size(), 0);
                chk("final_empty_lsb", int'(emp_l), 1);
                end_done = 1'b1;
            end
        end
    end

    task automatic drive(input bit v, input logic [15:0] d, input bit r);
        valid_i      = v;
        data_i       = d;
        byte_ready_i = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() > 0 || pend > 0) && n < 400) begin
            drive(1'b0, 16'h0, 1'b1);
            n++;
        end
        if (n >= 400) drain_timeout = 1'b1;
        drive(1'b0, 16'h0, 1'b1);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        repeat (2) drive(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) drive(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b1);

        // single sample, full-rate drain
        drive(1'b1, 16'hA55A, 1'b1);
        repeat (5) drive(1'b0, 16'h0, 1'b1);

        // backpressure: byte must hold while ready is low
        drive(1'b1, 16'h8001, 1'b0);
        repeat (12) drive(1'b0, 16'h0, 1'b0);
        drain();

        // overflow: ready low, burst past capacity
        for (int i = 0; i < 20; i++) drive(1'b1, 16'(i), 1'b0);
        drive(1'b0, 16'h0, 1'b0);
        drain();

        // full FIFO with a write landing on the BYTE1 pop
        do_reset();
        for (int i = 0; i < 17; i++) drive(1'b1, 16'(16'h100 + i), 1'b0);
        repeat (2) drive(1'b0, 16'h0, 1'b0);
        drive(1'b0, 16'h0, 1'b1);
        drive(1'b1, 16'hBEEF, 1'b1);
        drain();

        // reset while a byte is pending and samples are queued
        for (int i = 0; i < 6; i++) drive(1'b1, 16'(16'h2000 + i), 1'b0);
        repeat (2) drive(1'b0, 16'h0, 1'b0);
        do_reset();
        repeat (5) drive(1'b0, 16'h0, 1'b1);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 99) < 45), 16'($urandom), ($urandom_range(0, 99) < 55));
        end
        drain();

        end_req = 1'b1;
        for (int n = 0; n < 10 && !end_done; n++) @(posedge clk);
        if (!end_done) begin
            $display("FAIL final_checks: not completed");
            $fatal(1, "final checks did not run");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
